// File: rtl/int_ctrl_if.sv
// Register lane between the address mapper and the interrupt controller:
// word address, write data, write strobe and combinational read data.
interface int_ctrl_if;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;

  modport master (output a, output d, output we, input spo);
  modport slave  (input a, input d, input we, output spo);
endinterface

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller. Raw sources are synchronised and
// edge-detected, latched into PENDING (edge or level per MODE), masked by
// ENABLE, prioritised (lowest index wins) and reduced to one registered
// irq_o. Reads are combinational and have no side effects.
module int_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  int_ctrl_if.slave        bus,
  output logic             irq_o
);

  localparam int PAD = 32 - N_SRC;

  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_MODE    = 3'd2,
    REG_CLAIM   = 3'd3,
    REG_ACTIVE  = 3'd4,
    REG_GLOBAL  = 3'd5,
    REG_SWSET   = 3'd6,
    REG_RSVD    = 3'd7
  } reg_addr_e;

  logic [N_SRC-1:0] s1, s2, s3;
  logic [N_SRC-1:0] pending, enable, mode;
  logic             global_en;

  logic [N_SRC-1:0] rise, active;
  logic [N_SRC-1:0] w1c_mask, swset_mask, done_mask;
  logic [N_SRC-1:0] edge_nxt, level_nxt, pending_nxt;
  logic             claim_valid;
  logic [4:0]       claim_id;

  logic wr_pending, wr_enable, wr_mode, wr_claim, wr_global, wr_swset;

  // Only a few low bits of the write data reach registers for small N_SRC.
  logic unused_d_bits;
  assign unused_d_bits = ^bus.d;

  assign wr_pending = bus.we && (bus.a == REG_PENDING);
  assign wr_enable  = bus.we && (bus.a == REG_ENABLE);
  assign wr_mode    = bus.we && (bus.a == REG_MODE);
  assign wr_claim   = bus.we && (bus.a == REG_CLAIM);
  assign wr_global  = bus.we && (bus.a == REG_GLOBAL);
  assign wr_swset   = bus.we && (bus.a == REG_SWSET);

  assign rise   = s2 & ~s3;
  assign active = pending & enable;

  // Two-flop synchroniser per source plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Decode bus writes into clear / set / completion masks; an out-of-range
  // completion id simply matches no source.
  always_comb begin
    w1c_mask   = '0;
    swset_mask = '0;
    done_mask  = '0;
    if (wr_pending) w1c_mask   = bus.d[N_SRC-1:0];
    if (wr_swset)   swset_mask = bus.d[N_SRC-1:0];
    for (int i = 0; i < N_SRC; i++) begin
      if (wr_claim && (bus.d[4:0] == 5'(i))) done_mask[i] = 1'b1;
    end
  end

  // Edge bits hold until cleared and a same-cycle set beats the clear;
  // level bits follow the synchronised line every cycle.
  assign edge_nxt    = (pending & ~(w1c_mask | done_mask)) | rise | swset_mask;
  assign level_nxt   = s2 | swset_mask;
  assign pending_nxt = (mode & edge_nxt) | (~mode & level_nxt);

  // Software-visible state and the registered request to the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      enable    <= '0;
      mode      <= '0;
      global_en <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (wr_enable) enable    <= bus.d[N_SRC-1:0];
      if (wr_mode)   mode      <= bus.d[N_SRC-1:0];
      if (wr_global) global_en <= bus.d[0];
      irq_o <= global_en & (|active);
    end
  end

  // Priority encoder: scanning downwards leaves the lowest active index.
  always_comb begin
    claim_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) claim_id = 5'(i);
    end
  end

  assign claim_valid = |active;

  // Combinational read mux; unused high bits and write-only slots read 0.
  always_comb begin
    bus.spo = '0;
    case (bus.a)
      REG_PENDING: bus.spo = {{PAD{1'b0}}, pending};
      REG_ENABLE:  bus.spo = {{PAD{1'b0}}, enable};
      REG_MODE:    bus.spo = {{PAD{1'b0}}, mode};
      REG_CLAIM:   bus.spo = {claim_valid, 26'd0, claim_id};
      REG_ACTIVE:  bus.spo = {{PAD{1'b0}}, active};
      REG_GLOBAL:  bus.spo = {31'd0, global_en};
      REG_SWSET:   bus.spo = '0;
      REG_RSVD:    bus.spo = '0;
      default:     bus.spo = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: directed scenarios plus random register traffic,
// checked by a scoreboard against a cycle-level behavioural model.
module tb_int_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] src;
  logic       irq_o;
  logic       rd_req;

  int_ctrl_if bus ();

  int_ctrl #(.N_SRC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .src   (src),
    .bus   (bus),
    .irq_o (irq_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_val_q[$];
  string       exp_name_q[$];

  // Behavioural model state
  logic [7:0] m_pend, m_en, m_mode;
  logic       m_glob, m_irq;
  logic [7:0] samp[$];

  int          lat;
  int          op;
  logic [2:0]  addr;
  logic [31:0] data;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_en   = '0;
    m_mode = '0;
    m_glob = 1'b0;
    m_irq  = 1'b0;
    samp   = '{8'h00, 8'h00, 8'h00};
  endtask

  // One clock of the controller's rules; samp[0..2] are src as sampled at
  // the previous one, two and three edges.
  task automatic model_step();
    logic [7:0] sync_now, sync_old, w1c, sws, cmp, nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sync_now = samp[1];
    sync_old = samp[2];
    w1c = (bus.we && bus.a == 3'd0) ? bus.d[7:0] : 8'h00;
    sws = (bus.we && bus.a == 3'd6) ? bus.d[7:0] : 8'h00;
    cmp = 8'h00;
    if (bus.we && bus.a == 3'd3 && bus.d[4:0] < 5'd8) cmp[bus.d[2:0]] = 1'b1;
    m_irq = m_glob && ((m_pend & m_en) != 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (!m_mode[i])                                      nxt[i] = sync_now[i] | sws[i];
      else if ((sync_now[i] && !sync_old[i]) || sws[i])    nxt[i] = 1'b1;
      else if (w1c[i] || cmp[i])                           nxt[i] = 1'b0;
      else                                                 nxt[i] = m_pend[i];
    end
    m_pend = nxt;
    if (bus.we) begin
      case (bus.a)
        3'd1: m_en   = bus.d[7:0];
        3'd2: m_mode = bus.d[7:0];
        3'd5: m_glob = bus.d[0];
        default: ;
      endcase
    end
    samp.push_front(src);
    void'(samp.pop_back());
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] ra);
    logic [7:0]  act;
    logic [31:0] r;
    act = m_pend & m_en;
    r = 32'h0;
    case (ra)
      3'd0: r = {24'd0, m_pend};
      3'd1: r = {24'd0, m_en};
      3'd2: r = {24'd0, m_mode};
      3'd3: for (int i = 7; i >= 0; i--) if (act[i]) r = 32'h8000_0000 | 32'(i);
      3'd4: r = {24'd0, act};
      3'd5: r = {31'd0, m_glob};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Monitor: compares read data whenever a read is presented, and irq_o
  // every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rd_req) begin
      if (exp_val_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL scoreboard_underflow: got read 0x%08h, expected a queued value", bus.spo);
      end else begin
        check_output(exp_name_q.pop_front(), bus.spo, exp_val_q.pop_front());
      end
    end
    check_output("irq_model", 32'(irq_o), 32'(m_irq));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] wa, input logic [31:0] wd);
    bus.a  = wa;
    bus.d  = wd;
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [2:0] ra, input logic [31:0] exp);
    bus.a  = ra;
    rd_req = 1'b1;
    exp_name_q.push_back(name);
    exp_val_q.push_back(exp);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic read_model(input logic [2:0] ra);
    read_expect("rand_read", ra, model_read(ra));
  endtask

  initial begin
    rst_n  = 1'b0;
    src    = 8'hFF;
    bus.a  = 3'd0;
    bus.d  = 32'h0;
    bus.we = 1'b0;
    rd_req = 1'b0;
    repeat (2) tick();

    // Reset: everything reads 0 while held
    for (int i = 0; i < 8; i++) read_expect("reset_read", 3'(i), 32'h0);
    check_output("reset_irq", 32'(irq_o), 32'h0);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    read_expect("release_pending", 3'd0, 32'h0000_00FF);
    check_output("release_irq", 32'(irq_o), 32'h0);

    // Clean up, then edge path
    src = 8'h00;
    repeat (3) tick();
    apply_stimulus(3'd2, 32'hFF);
    apply_stimulus(3'd0, 32'hFF);
    apply_stimulus(3'd1, 32'h08);
    apply_stimulus(3'd5, 32'h01);
    src[3] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      tick();
      if (c == 2) src[3] = 1'b0;
      if (irq_o) lat = c;
    end
    check_output("edge_latency", 32'(lat), 32'd4);
    read_expect("edge_claim", 3'd3, 32'h8000_0003);
    apply_stimulus(3'd3, 32'd3);
    check_output("edge_irq_hold", 32'(irq_o), 32'h1);
    tick();
    check_output("edge_irq_drop", 32'(irq_o), 32'h0);

    // Priority
    apply_stimulus(3'd1, 32'hFF);
    src = 8'h24;
    repeat (2) tick();
    src = 8'h00;
    repeat (2) tick();
    read_expect("prio_claim_first", 3'd3, 32'h8000_0002);
    apply_stimulus(3'd3, 32'd2);
    read_expect("prio_claim_second", 3'd3, 32'h8000_0005);
    apply_stimulus(3'd3, 32'd5);
    read_expect("prio_claim_none", 3'd3, 32'h0);

    // Level mode
    apply_stimulus(3'd2, 32'h00);
    apply_stimulus(3'd1, 32'h01);
    src = 8'h01;
    repeat (4) tick();
    check_output("level_irq_on", 32'(irq_o), 32'h1);
    apply_stimulus(3'd0, 32'h01);
    read_expect("level_pending_back", 3'd0, 32'h01);
    check_output("level_irq_hold", 32'(irq_o), 32'h1);
    src = 8'h00;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      tick();
      if (!irq_o) lat = c;
    end
    check_output("level_fall_latency", 32'(lat), 32'd4);

    // Simultaneous edge set and W1C
    apply_stimulus(3'd2, 32'hFF);
    apply_stimulus(3'd0, 32'hFF);
    apply_stimulus(3'd1, 32'h02);
    src = 8'h02;
    repeat (2) tick();
    apply_stimulus(3'd0, 32'h02);
    read_expect("set_beats_clear", 3'd0, 32'h02);
    apply_stimulus(3'd0, 32'h02);

    // SWSET and a completion with an out-of-range id
    apply_stimulus(3'd1, 32'h40);
    apply_stimulus(3'd6, 32'h40);
    check_output("swset_irq_before", 32'(irq_o), 32'h0);
    tick();
    check_output("swset_irq_after", 32'(irq_o), 32'h1);
    apply_stimulus(3'd3, 32'd31);
    read_expect("cmp31_pending", 3'd0, 32'h40);
    read_expect("cmp31_claim", 3'd3, 32'h8000_0006);
    check_output("cmp31_irq", 32'(irq_o), 32'h1);

    // Asynchronous reset between edges
    src = 8'h00;
    tick();
    check_output("pre_reset_irq", 32'(irq_o), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_output("async_reset_irq", 32'(irq_o), 32'h0);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) read_expect("post_reset_read", 3'(i), 32'h0);

    // Random traffic against the model
    apply_stimulus(3'd5, 32'h01);
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 9));
      if (op < 4) begin
        read_model(3'($urandom_range(0, 7)));
      end else if (op < 8) begin
        addr = 3'($urandom_range(0, 7));
        data = (addr == 3'd3) ? 32'($urandom_range(0, 31)) : 32'($urandom);
        apply_stimulus(addr, data);
      end else begin
        src = 8'($urandom);
        tick();
      end
    end

    tick();
    if (exp_val_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL scoreboard_leftover: got %0d unread entries, expected 0", exp_val_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
